// File: rtl/rtlola_sched_pkg.sv
// Shared definitions for the RTLola evaluation scheduler: slot kinds,
// default widths/periods and the buffered event entry layout.
package rtlola_sched_pkg;

    localparam logic [1:0] KIND_NONE  = 2'b00;
    localparam logic [1:0] KIND_EVENT = 2'b01;
    localparam logic [1:0] KIND_PER   = 2'b10;
    localparam logic [1:0] KIND_BOTH  = 2'b11;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_TS_W   = 64;

    localparam int unsigned DEF_PERIOD_0 = 1000;
    localparam int unsigned DEF_PERIOD_1 = 2000;
    localparam int unsigned DEF_PERIOD_2 = 0;
    localparam int unsigned DEF_PERIOD_3 = 0;

    // Buffered input event; narrower instance widths zero-extend into it.
    typedef struct packed {
        logic [DEF_TS_W-1:0]   ts;
        logic [DEF_DATA_W-1:0] data;
    } evt_t;

endpackage

// File: rtl/rtlola_event_fifo.sv
// Small synchronous FIFO for timestamped input events. A push into a full
// FIFO is accepted when a pop happens in the same cycle; otherwise it is
// reported on drop.
module rtlola_event_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head,
    output logic         drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign head    = mem[rd_ptr];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rtlola_eval_scheduler.sv
// Front-end for the RTLola monitor pipeline: timestamps input events,
// generates periodic deadlines and issues one ordered slot per cycle.
module rtlola_eval_scheduler
    import rtlola_sched_pkg::*;
#(
    parameter int          DATA_W     = DEF_DATA_W,
    parameter int          TS_W       = DEF_TS_W,
    parameter int          FIFO_DEPTH = 4,
    parameter int          NUM_PER    = 2,
    parameter int unsigned PERIOD_0   = DEF_PERIOD_0,
    parameter int unsigned PERIOD_1   = DEF_PERIOD_1,
    parameter int unsigned PERIOD_2   = DEF_PERIOD_2,
    parameter int unsigned PERIOD_3   = DEF_PERIOD_3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] input_0,
    input  logic              new_input_0,
    input  logic              pipe_ready,
    output logic              issue_valid,
    output logic [1:0]        issue_kind,
    output logic [TS_W-1:0]   issue_ts,
    output logic [DATA_W-1:0] issue_data,
    output logic [3:0]        issue_mask,
    output logic              fifo_overflow,
    output logic              deadline_overrun
);

    localparam int unsigned PER_ARR [4] = '{PERIOD_0, PERIOD_1, PERIOD_2, PERIOD_3};

    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] ts_next;
    logic [3:0]      fire_mask;

    logic            pend_vld;
    logic [TS_W-1:0] pend_ts;
    logic [3:0]      pend_mask;

    evt_t            push_e;
    evt_t            head_e;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_drop;
    logic [TS_W-1:0] head_ts;

    logic [1:0]      sel;
    logic            issue_now;
    logic            pop_evt;
    logic            pop_per;

    assign ts_next = ts + TS_W'(1);

    // Free-running time base, advancing only on enabled cycles.
    always_ff @(posedge clk) begin
        if (rst)     ts <= '0;
        else if (en) ts <= ts_next;
    end

    // One down-counter per periodic stream; reaching 0 fires the deadline
    // that belongs to the next timestamp.
    for (genvar k = 0; k < 4; k++) begin : g_per
        if (k < NUM_PER) begin : g_on
            localparam logic [31:0] RELOAD = 32'(PER_ARR[k] - 1);
            logic [31:0] cnt;

            // Period counter with reload on expiry.
            always_ff @(posedge clk) begin
                if (rst)              cnt <= RELOAD;
                else if (en) begin
                    if (cnt == '0)    cnt <= RELOAD;
                    else              cnt <= cnt - 32'd1;
                end
            end

            assign fire_mask[k] = en && (cnt == '0);
        end else begin : g_off
            assign fire_mask[k] = 1'b0;
        end
    end

    assign push_e.ts   = DEF_TS_W'(ts);
    assign push_e.data = DEF_DATA_W'(input_0);
    assign head_ts     = head_e.ts[TS_W-1:0];

    rtlola_event_fifo #(
        .W     ($bits(evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (en && new_input_0),
        .pop   (pop_evt),
        .din   (push_e),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head_e),
        .drop  (fifo_drop)
    );

    // Arbiter: oldest timestamp wins, equal timestamps share one slot.
    always_comb begin
        sel = KIND_NONE;
        if (pend_vld && !fifo_empty) begin
            if (pend_ts < head_ts)      sel = KIND_PER;
            else if (head_ts < pend_ts) sel = KIND_EVENT;
            else                        sel = KIND_BOTH;
        end else if (pend_vld) begin
            sel = KIND_PER;
        end else if (!fifo_empty) begin
            sel = KIND_EVENT;
        end
    end

    assign issue_now = en && pipe_ready && (sel != KIND_NONE);
    assign pop_evt   = issue_now && sel[0];
    assign pop_per   = issue_now && sel[1];

    // Single pending deadline entry. Fires landing on a still-unissued
    // entry of another timestamp are folded in and flagged as overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld         <= 1'b0;
            pend_ts          <= '0;
            pend_mask        <= '0;
            deadline_overrun <= 1'b0;
        end else if (en) begin
            if (fire_mask != '0) begin
                if (pend_vld && !pop_per) begin
                    pend_mask <= pend_mask | fire_mask;
                    if (pend_ts != ts_next) deadline_overrun <= 1'b1;
                end else begin
                    pend_vld  <= 1'b1;
                    pend_ts   <= ts_next;
                    pend_mask <= fire_mask;
                end
            end else if (pop_per) begin
                pend_vld  <= 1'b0;
                pend_mask <= '0;
            end
        end
    end

    // Sticky record of events lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (rst)            fifo_overflow <= 1'b0;
        else if (fifo_drop) fifo_overflow <= 1'b1;
    end

    // Registered slot outputs; fields hold between issues, valid pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid <= 1'b0;
            issue_kind  <= '0;
            issue_ts    <= '0;
            issue_data  <= '0;
            issue_mask  <= '0;
        end else begin
            issue_valid <= issue_now;
            if (issue_now) begin
                issue_kind <= sel;
                issue_ts   <= sel[1] ? pend_ts : head_ts;
                issue_data <= sel[0] ? head_e.data[DATA_W-1:0] : '0;
                issue_mask <= sel[1] ? pend_mask : '0;
            end
        end
    end

endmodule

// File: tb/tb_rtlola_eval_scheduler.sv
// Directed bench for rtlola_eval_scheduler with hand-derived slot sequences.
module tb_rtlola_eval_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic [63:0] input_0 = '0;
    logic        new_input_0 = 1'b0;
    logic        pipe_ready = 1'b0;
    logic        issue_valid;
    logic [1:0]  issue_kind;
    logic [63:0] issue_ts;
    logic [63:0] issue_data;
    logic [3:0]  issue_mask;
    logic        fifo_overflow;
    logic        deadline_overrun;

    typedef struct {
        logic [1:0]  kind;
        logic [63:0] ts;
        logic [63:0] data;
        logic [3:0]  mask;
    } slot_t;

    slot_t q[$];
    int    tnow = 0;
    int    n_chk = 0;
    int    n_pass = 0;

    rtlola_eval_scheduler #(
        .DATA_W(64), .TS_W(64), .FIFO_DEPTH(4), .NUM_PER(2),
        .PERIOD_0(1000), .PERIOD_1(2000), .PERIOD_2(0), .PERIOD_3(0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .input_0          (input_0),
        .new_input_0      (new_input_0),
        .pipe_ready       (pipe_ready),
        .issue_valid      (issue_valid),
        .issue_kind       (issue_kind),
        .issue_ts         (issue_ts),
        .issue_data       (issue_data),
        .issue_mask       (issue_mask),
        .fifo_overflow    (fifo_overflow),
        .deadline_overrun (deadline_overrun)
    );

    always #5 clk = ~clk;

    // Record every issued slot, sampled mid-cycle.
    always @(negedge clk) begin
        if (issue_valid) q.push_back('{issue_kind, issue_ts, issue_data, issue_mask});
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, tnow);
    endtask

    function automatic slot_t slot_at(input int i);
        slot_t s;
        s = '{2'b00, 64'd0, 64'd0, 4'd0};
        if (i < q.size()) s = q[i];
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (en && !rst) tnow++;
    endtask

    task automatic run_to(input int t);
        while (tnow < t) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tnow = 0;
        q.delete();
    endtask

    task automatic strobe(input logic [63:0] v);
        input_0 = v;
        new_input_0 = 1'b1;
        tick();
        new_input_0 = 1'b0;
    endtask

    slot_t s;

    initial begin
        // Idle run: periodic slots only; an en=0 strobe must be ignored.
        pipe_ready = 1'b1;
        do_reset();
        chk("rst_valid", issue_valid, 0);
        chk("rst_kind", issue_kind, 0);
        chk("rst_ts", issue_ts, 0);
        chk("rst_ovf", fifo_overflow, 0);
        chk("rst_ovr", deadline_overrun, 0);
        run_to(50);
        en = 1'b0;
        input_0 = 64'd9;
        new_input_0 = 1'b1;
        tick();
        new_input_0 = 1'b0;
        en = 1'b1;
        run_to(2100);
        chk("idle_count", q.size(), 2);
        s = slot_at(0);
        chk("idle0_kind", s.kind, 2'b10);
        chk("idle0_ts", s.ts, 1000);
        chk("idle0_mask", s.mask, 4'b0001);
        chk("idle0_data", s.data, 0);
        s = slot_at(1);
        chk("idle1_kind", s.kind, 2'b10);
        chk("idle1_ts", s.ts, 2000);
        chk("idle1_mask", s.mask, 4'b0011);

        // Single event: slot exactly two cycles after the strobe.
        do_reset();
        run_to(5);
        strobe(64'd1);
        chk("evt_early", issue_valid, 0);
        tick();
        chk("evt_valid", issue_valid, 1);
        chk("evt_kind", issue_kind, 2'b01);
        chk("evt_ts", issue_ts, 5);
        chk("evt_data", issue_data, 1);
        chk("evt_mask", issue_mask, 0);
        tick();
        chk("evt_pulse", issue_valid, 0);
        chk("evt_hold", issue_kind, 2'b01);

        // Event at ts 1000 shares a slot with deadline 0 (held one cycle).
        run_to(999);
        q.delete();
        pipe_ready = 1'b0;
        tick();
        strobe(64'd7);
        pipe_ready = 1'b1;
        tick();
        chk("both_valid", issue_valid, 1);
        chk("both_kind", issue_kind, 2'b11);
        chk("both_ts", issue_ts, 1000);
        chk("both_data", issue_data, 7);
        chk("both_mask", issue_mask, 4'b0001);
        run_to(1010);
        chk("both_count", q.size(), 1);

        // Overflow: fifth event dropped, first four issued in order.
        pipe_ready = 1'b0;
        do_reset();
        run_to(10);
        for (int i = 1; i <= 5; i++) begin
            strobe(64'(i));
            if (i == 4) chk("ovf_before", fifo_overflow, 0);
        end
        chk("ovf_set", fifo_overflow, 1);
        pipe_ready = 1'b1;
        run_to(tnow + 8);
        chk("ovf_count", q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            s = slot_at(i);
            chk("ovf_kind", s.kind, 2'b01);
            chk("ovf_ts", s.ts, 64'(10 + i));
            chk("ovf_data", s.data, 64'(i + 1));
        end

        // Push into full FIFO in the same cycle as a pop is accepted.
        pipe_ready = 1'b0;
        do_reset();
        run_to(10);
        for (int i = 1; i <= 4; i++) strobe(64'(i));
        pipe_ready = 1'b1;
        strobe(64'd5);
        run_to(tnow + 8);
        chk("pp_ovf", fifo_overflow, 0);
        chk("pp_count", q.size(), 5);
        s = slot_at(4);
        chk("pp_ts", s.ts, 14);
        chk("pp_data", s.data, 5);

        // Long stall: second fire merges into the older pending entry.
        do_reset();
        run_to(900);
        pipe_ready = 1'b0;
        run_to(1500);
        chk("ovr_single", deadline_overrun, 0);
        run_to(2100);
        chk("ovr_set", deadline_overrun, 1);
        chk("ovr_none", q.size(), 0);
        pipe_ready = 1'b1;
        run_to(2110);
        chk("ovr_count", q.size(), 1);
        s = slot_at(0);
        chk("ovr_kind", s.kind, 2'b10);
        chk("ovr_ts", s.ts, 1000);
        chk("ovr_mask", s.mask, 4'b0011);

        // Reset with three queued events: outputs clear, nothing stale.
        pipe_ready = 1'b0;
        strobe(64'd11);
        strobe(64'd12);
        strobe(64'd13);
        rst = 1'b1;
        tick();
        chk("mr_valid", issue_valid, 0);
        chk("mr_kind", issue_kind, 0);
        chk("mr_ts", issue_ts, 0);
        chk("mr_data", issue_data, 0);
        chk("mr_mask", issue_mask, 0);
        chk("mr_ovf", fifo_overflow, 0);
        chk("mr_ovr", deadline_overrun, 0);
        rst = 1'b0;
        tnow = 0;
        q.delete();
        pipe_ready = 1'b1;
        run_to(20);
        chk("mr_stale", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rtlola_eval_scheduler.md
Name: rtlola_eval_scheduler

Overview:
- Sits in front of the pipelined RTLola monitor topEntity.
- Timestamps incoming input events and buffers them in a small FIFO.
- Generates periodic-stream deadlines from a free-running time base.
- Arbitrates both sources into one ordered stream of evaluation slots, issued only when the pipeline signals ready.

Parameters:
- DATA_W, 64, width of input_0 value (signed)
- TS_W, 64, timestamp counter width
- FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2)
- NUM_PER, 2, number of periodic streams (1..4)
- PERIOD_0..PERIOD_3, 1000/2000/0/0, deadline period in clk cycles per periodic stream (>=1 for k<NUM_PER; unused otherwise)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- en  in  1  global enable; 0 freezes all state
- input_0  in  DATA_W  event value, valid with new_input_0
- new_input_0  in  1  one-cycle event strobe
- pipe_ready  in  1  monitor pipeline can accept a slot this cycle
- issue_valid  out  1  one-cycle slot strobe
- issue_kind  out  2  bit0 = event present, bit1 = periodic present
- issue_ts  out  TS_W  slot timestamp
- issue_data  out  DATA_W  event value (0 if bit0 clear)
- issue_mask  out  4  due periodic streams (0 if bit1 clear)
- fifo_overflow  out  1  sticky: event dropped
- deadline_overrun  out  1  sticky: deadline merged into a pending one

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high, named rst.
  - rst=1 clears all outputs to 0, ts to 0, FIFO to empty, pending deadline to empty.
  - Each period counter k loads PERIOD_k-1.
  - rst has priority over en.
  - Reset mid-operation discards queued events and pending deadlines with no issue.
- Time base: ts increments by 1 on each en=1 cycle; wraps modulo 2^TS_W.
- Deadlines:
  - Counter k decrements when en=1.
  - On 0 it reloads PERIOD_k-1 and fires at timestamp ts+1 (i.e. deadline k occurs at ts = n*PERIOD_k, n>=1).
  - Deadlines firing in the same cycle merge into one pending entry: pend_mask OR, pend_ts.
  - If a deadline fires while a pending entry with a different ts is still unissued:
    - OR it into pend_mask;
    - keep the older pend_ts;
    - set deadline_overrun.
- Event capture:
  - new_input_0=1 with en=1 pushes {ts, input_0} into the FIFO.
  - Full FIFO: drop the event and set fifo_overflow.
  - Exception: push and pop in the same cycle while full is accepted.
  - new_input_0 with en=0 is ignored.
- Arbitration (combinational decision in cycle t, outputs registered at t+1). Only when en=1 and pipe_ready=1:
  - Pending only, or pend_ts < head_ts: issue periodic (kind 10).
  - FIFO only, or head_ts < pend_ts: issue event (kind 01).
  - pend_ts == head_ts: one combined slot (kind 11) with data and mask; pop both.
  - Neither source: no issue.
- Timing and throughput:
  - Max one slot per cycle.
  - issue_valid is a single-cycle pulse; the other issue_* fields hold their value until the next issue.
  - Minimum latency strobe → issue_valid is 2 cycles (push at t+1, issue registered at t+2).
  - pipe_ready=0 stalls issue with no loss until FIFO or pending capacity is exceeded.
- Comparison rule: timestamps compare unsigned, no wrap handling (TS_W=64 never wraps in practice).
- Ordering guarantee: issue_ts is non-decreasing across slots, barring overrun.

Decomposition:
- Shared package rtlola_sched_pkg holds:
  - slot-kind constants KIND_EVENT=2'b01, KIND_PER=2'b10, KIND_BOTH=2'b11;
  - the event entry struct {ts, data};
  - the PERIOD defaults.
- One natural sub-module: rtlola_event_fifo, a synchronous FIFO with push/pop/full/empty/head and the simultaneous push-pop-when-full rule.
- Deadline generator and arbiter stay in the top.

Test Plan:
- Reset then idle with pipe_ready=1, PERIOD_0=1000, PERIOD_1=2000:
  - slots kind 10 at ts 1000 (mask 0001) and ts 2000 (mask 0011);
  - no other issue_valid.
- Strobe input_0=1 at ts 5: issue kind 01, ts 5, data 1, exactly 2 cycles after the strobe.
- Strobe input_0=7 at ts 1000, coinciding with deadline 0: single slot kind 11, ts 1000, data 7, mask 0001.
- pipe_ready=0, five strobes values 1..5 at ts 10..14:
  - fifo_overflow=1 after the fifth;
  - on ready, slots 1,2,3,4 in order with ts 10..13.
- pipe_ready=0 from ts 900 to 2100: deadline_overrun=1; one slot kind 10, ts 1000, mask 0011.
- rst pulse while the FIFO holds 3 entries: all outputs 0 next cycle; no stale slots issued afterwards.
